// File: rtl/arb_pkg.sv
// arb_pkg -- shared types, constants and helpers for the ring_arbiter4 block.
//   NUM_REQ    : number of requesting agents (fixed at 4)
//   arb_state_e: arbiter state (idle / resource owned)
//   TOKEN_RST  : priority token value after reset (agent 0 highest)
//   onehot_to_idx: encode a 4-bit one-hot vector, 0 for all-zero
//   rotl1      : rotate a 4-bit vector left by one (agent n -> agent n+1)
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam logic [NUM_REQ-1:0] TOKEN_RST = 4'b0001;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] vec);
    logic [1:0] idx;
    case (vec)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] rotl1(input logic [NUM_REQ-1:0] vec);
    return {vec[NUM_REQ-2:0], vec[NUM_REQ-1]};
  endfunction

endpackage

// File: rtl/ring_arbiter4_if.sv
// ring_arbiter4_if -- request/grant bundle between the agents and the arbiter.
//   req      : per-agent request, level-held while the agent wants/uses the resource
//   grant    : one-hot grant (all-zero when idle)
//   grant_id : encoded index of the granted agent, 0 when idle
//   busy     : high whenever grant is non-zero
//   preempt  : one-cycle pulse when a grant is revoked by the hold limit
// Modports: master = agent side, slave = arbiter side.
interface ring_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic               busy;
  logic               preempt;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output preempt
  );

endinterface

// File: rtl/rr_pick4.sv
// rr_pick4 -- combinational round-robin pick for four requesters.
// Scans req starting at the one-hot token position, wrapping 0->1->2->3->0;
// the first set bit wins.
//   req    : candidate requests
//   token  : one-hot highest-priority position
//   winner : one-hot winner (zero when no request)
//   valid  : at least one request present
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] token,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [1:0]         start_s;
  logic [NUM_REQ-1:0] winner_s;
  logic               found_s;

  // Walk the ring from the token; the 2-bit position wraps naturally.
  always_comb begin
    start_s  = onehot_to_idx(token);
    winner_s = 4'b0000;
    found_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      winner_s[start_s + 2'(k)] = req[start_s + 2'(k)] & ~found_s;
      found_s                   = found_s | req[start_s + 2'(k)];
    end
  end

  assign winner = winner_s;
  assign valid  = found_s;

endmodule

// File: rtl/ring_arbiter4.sv
// ring_arbiter4 -- four-requester round-robin arbiter with rotating one-hot token.
// Optional feature macro: ARB_HOLD_LIMIT_EN (hold-limit preemption after MAX_HOLD
// consecutive granted cycles while another agent waits). Without it the owner
// keeps the resource until it drops req and preempt is constant 0.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : ring_arbiter4_if.slave (req in; grant, grant_id, busy, preempt out,
//           all outputs registered)
// Parameter:
//   MAX_HOLD : consecutive grant cycles before preemption, legal 2..255
module ring_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            reset,
  ring_arbiter4_if.slave  bus
);

  // Elaboration-time range check on the hold limit.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("ring_arbiter4: MAX_HOLD must be within 2..255");
  end

  arb_state_e         state_r, state_s;
  logic [NUM_REQ-1:0] token_r, token_s;
  logic [NUM_REQ-1:0] grant_r, grant_s;
  logic [1:0]         grant_id_r;
  logic               busy_r;
  logic               preempt_r, preempt_s;

  logic               owner_req_s;
  logic               others_s;
  logic               limit_hit_s;
  logic [NUM_REQ-1:0] pick_req_s;
  logic [NUM_REQ-1:0] pick_tok_s;
  logic [NUM_REQ-1:0] pick_win_s;
  logic               pick_valid_s;

  // While owned, the only decision is a handover: the owner is masked out and
  // the scan begins one past it, which is exactly where the token will move.
  always_comb begin
    owner_req_s = |(bus.req & grant_r);
    others_s    = |(bus.req & ~grant_r);
    if (state_r == ARB_OWNED) begin
      pick_req_s = bus.req & ~grant_r;
      pick_tok_s = rotl1(grant_r);
    end else begin
      pick_req_s = bus.req;
      pick_tok_s = token_r;
    end
  end

  rr_pick4 u_pick (
    .req    (pick_req_s),
    .token  (pick_tok_s),
    .winner (pick_win_s),
    .valid  (pick_valid_s)
  );

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt_r, hold_cnt_s;

  // The edge ending the MAX_HOLD-th granted cycle sees a count of MAX_HOLD-1.
  always_comb begin
    limit_hit_s = (hold_cnt_r >= 8'(MAX_HOLD - 1));
  end

  // Count granted cycles: clear on any new grant or idle, saturate at MAX_HOLD.
  always_comb begin
    hold_cnt_s = 8'd0;
    if (grant_s != grant_r) begin
      hold_cnt_s = 8'd0;
    end else if ((grant_s != 4'b0000) && (hold_cnt_r < 8'(MAX_HOLD))) begin
      hold_cnt_s = hold_cnt_r + 8'd1;
    end else if (grant_s != 4'b0000) begin
      hold_cnt_s = hold_cnt_r;
    end else begin
      hold_cnt_s = 8'd0;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= 8'd0;
    end else begin
      hold_cnt_r <= hold_cnt_s;
    end
  end
`else
  // No hold limit: the owner is never preempted.
  always_comb begin
    limit_hit_s = 1'b0;
  end
`endif

  // Next-state, next-token and next-grant decision.
  always_comb begin
    state_s   = state_r;
    token_s   = token_r;
    grant_s   = 4'b0000;
    preempt_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_s = ARB_OWNED;
          grant_s = pick_win_s;
        end else begin
          state_s = ARB_IDLE;
          grant_s = 4'b0000;
        end
      end
      ARB_OWNED: begin
        if (owner_req_s && !(limit_hit_s && others_s)) begin
          grant_s = grant_r;
        end else begin
          // Release or revocation: token moves past the owner either way.
          token_s = rotl1(grant_r);
          if (pick_valid_s) begin
            grant_s   = pick_win_s;
            // Owner still requesting here means it was revoked, not released.
            preempt_s = owner_req_s;
          end else begin
            state_s = ARB_IDLE;
            grant_s = 4'b0000;
          end
        end
      end
      default: begin
        state_s = ARB_IDLE;
        grant_s = 4'b0000;
      end
    endcase
  end

  // State, token and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      token_r    <= TOKEN_RST;
      grant_r    <= 4'b0000;
      grant_id_r <= 2'd0;
      busy_r     <= 1'b0;
      preempt_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      token_r    <= token_s;
      grant_r    <= grant_s;
      grant_id_r <= onehot_to_idx(grant_s);
      busy_r     <= |grant_s;
      preempt_r  <= preempt_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;
  assign bus.preempt  = preempt_r;

endmodule

// File: tb/tb_ring_arbiter4.sv
// tb_ring_arbiter4 -- directed, table-driven bench for ring_arbiter4 (MAX_HOLD=4).
// Expectations for the hold-limit sequences follow ARB_HOLD_LIMIT_EN.
module tb_ring_arbiter4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ring_arbiter4_if bus ();

  ring_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       preempt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] g,
                     input logic [1:0] id, input logic b);
    vec_t v;
    v.rst = rst; v.req = req; v.grant = g; v.id = id; v.busy = b; v.preempt = 1'b0;
    vecs.push_back(v);
  endtask

  // Drive inputs mid-cycle, then sample just after the following rising edge.
  task automatic step(input logic rst, input logic [3:0] req);
    @(negedge clk);
    reset   = rst;
    bus.req = req;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic ep);
    checks++;
    if (bus.grant !== eg || bus.grant_id !== eid || bus.busy !== eb || bus.preempt !== ep) begin
      failures++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b preempt=%b, want grant=%b id=%0d busy=%b preempt=%b",
               tag, bus.grant, bus.grant_id, bus.busy, bus.preempt, eg, eid, eb, ep);
    end
  endtask

  initial begin
    logic       hold_en;
    logic [3:0] eg;
    logic [1:0] eid;
    logic       ep;
    checks   = 0;
    failures = 0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    reset   = 1'b1;
    bus.req = 4'b0000;

    // reset with all requests, then single requester
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    // release to idle, idle stays idle, new request after 1 cycle
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    // rotation fairness with req=1111, owner drops for one cycle
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1);
    // back-to-back handovers, then wrap and skip
    add(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // idle with token at 3: scan 3,0,1; non-owners toggle during ownership
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1011, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id, vecs[i].busy, vecs[i].preempt);
    end

    // Hold limit with a competitor (token at agent 0)
    step(1'b0, 4'b0001);
    check("hold_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 4'b0101);
      if (hold_en && k >= 4) begin
        eg = 4'b0100; eid = 2'd2; ep = (k == 4);
      end else begin
        eg = 4'b0001; eid = 2'd0; ep = 1'b0;
      end
      check($sformatf("hold_comp%0d", k), eg, eid, 1'b1, ep);
    end

    // Hold limit with no competitor: counter saturates, no preemption
    step(1'b0, 4'b0000);
    check("hold_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0001);
    check("solo_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'b0001);
      check($sformatf("solo_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    // competitor arrives after saturation: immediate revoke when enabled
    step(1'b0, 4'b0011);
    if (hold_en) begin
      eg = 4'b0010; eid = 2'd1; ep = 1'b1;
    end else begin
      eg = 4'b0001; eid = 2'd0; ep = 1'b0;
    end
    check("sat_revoke", eg, eid, 1'b1, ep);

    // Reset mid-grant
    step(1'b0, 4'b0000);
    check("pre_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b1000);
    check("pre_rst_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1111);
    check("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b1111);
    check("post_reset_agent0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_arbiter4.md
# ring_arbiter4

Four-requester round-robin arbiter that shares one resource between four agents, using a rotating one-hot priority token. It sits between the requesting agents and the shared resource and drives a registered one-hot grant plus an encoded grant index. An optional hold-limit preempts a requester that keeps the resource too long while others wait.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles before preemption (only with ARB_HOLD_LIMIT_EN); legal range 2..255.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per agent; level-held while the agent wants or uses the resource.
- grant  output  4  registered one-hot grant, or all-zero when idle.
- grant_id  output  2  encoded index of the granted agent; 0 when idle.
- busy  output  1  high whenever grant is non-zero.
- preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State: IDLE (grant = 0) and OWNED (exactly one grant bit set). Priority token: 4-bit one-hot pointer marking the highest-priority agent.
- Reset values: grant = 4'b0000, grant_id = 0, busy = 0, preempt = 0, token = 4'b0001, hold counter = 0, state IDLE.
- Arbitration: scan req starting at the token position and wrap 0→1→2→3→0. The first set bit wins.
- IDLE → OWNED: any req bit set. The winner is granted on the next edge.
- OWNED, req[owner] still high: grant holds and the hold counter increments, saturating at MAX_HOLD.
- OWNED, req[owner] low: the token moves to owner+1 (mod 4).
  - If any other req is set, the next winner is granted on the same edge (no idle bubble). The scan starts from the new token.
  - Otherwise the arbiter goes to IDLE.
- A dropped request loses the grant permanently. Re-raising it re-enters arbitration behind the token.
- req bits for non-owners may toggle freely. Only their values in the release cycle matter.
- The arbiter never grants an agent whose req is low in the deciding cycle. The winner's req must be high on the edge that grants it.
- Reset asserted mid-grant: all outputs return to reset values on that edge, regardless of req.

## Timing
- Latency req→grant: 1 clock from idle (req sampled at edge N, grant visible after edge N).
- Release: req[owner] low sampled at edge N. grant changes (to the next owner or zero) after edge N.
- grant_id and busy change on the same edge as grant.
- preempt is high for exactly the cycle following the revoking edge.
- Worst-case wait with ARB_HOLD_LIMIT_EN: 3 × MAX_HOLD cycles plus 3 handover cycles.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - The hold counter is implemented. It resets to 0 on every new grant and counts granted cycles.
  - When the count reaches MAX_HOLD and another req bit is set, the grant is revoked and passed to the next winner on that edge, with the token advanced to owner+1. preempt pulses.
  - If no other agent requests, the owner keeps the grant and the counter stays saturated.
- ARB_HOLD_LIMIT_EN undefined:
  - No counter is implemented and MAX_HOLD is ignored. The owner holds until it drops req.
  - preempt is tied to 0.

## Structure
- Shared package arb_pkg: NUM_REQ = 4, state enum {ARB_IDLE, ARB_OWNED}, and the token reset constant 4'b0001.
- One natural sub-module, rr_pick4: combinational priority pick. Given req and token, it returns the one-hot winner and a valid flag.
- The top level holds state, token, grant and counter registers.

## Test plan
- Reset and single requester:
  - Hold reset 2 cycles with req=4'b1111 → grant=0, busy=0, token=0001.
  - Release reset with req=4'b0100 → grant=0100, grant_id=2 one cycle later.
- Rotation fairness: req=4'b1111 held, each owner drops its req for one cycle after owning → grants go 0001→0010→0100→1000→0001, with no idle cycles between them.
- Wrap and skip: token after owner 3, req=4'b0110 → grant=0010. After release with req=4'b0101 → grant=0100.
- Release to idle: the sole owner drops req → grant=0 next cycle. A new req=4'b0001 then grants after 1 cycle.
- Hold limit (macro on, MAX_HOLD=4): agent 0 holds, agent 2 requests → grant moves to 0100 after the 4th granted cycle and preempt pulses once.
  - Repeat with no competitor → agent 0 keeps the grant and preempt stays 0.
- Reset mid-grant: assert reset while grant=1000 and req=4'b1111 → all outputs are zero the next cycle. After reset, agent 0 wins first.
